fsk_window_controller: RTL and testbench
========================================

Name: fsk_window_controller

Overview:
- Sequences one frequency_analyzer instance into fixed-length measurement windows: clears it, holds off a guard interval, enables it for exactly WINDOW_TICKS cycles, waits for its pipeline to drain, then latches f0/f1 and issues a per-window symbol decision.
- Sits between the analyzer and the downstream demodulated-bit consumer.
- Runs single-shot or continuously, one symbol per window.

Parameters:
- WINDOW_TICKS, 50000, measurement window length in clock cycles (>=1); 1 ms at 50 MHz.
- GUARD_TICKS, 500, cycles after clear with analyzer disabled, to skip a partial half-period (0 skips the GUARD state).
- MIN_COUNT, 1000, minimum accumulated count (f0 or f1) for a window to be valid.
- SETTLE_TICKS, 2, cycles of drain after enable drops; covers the analyzer's registered check_result lag.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin one window; sampled only in IDLE
- continuous  in  1  when high at DECIDE, immediately start the next window
- analyzer_enable  out  1  to analyzer enable
- analyzer_clear  out  1  to analyzer clear (active-low)
- f0_value  in  32  analyzer f0 accumulation
- f1_value  in  32  analyzer f1 accumulation
- f0_latched  out  32  f0_value captured at window end
- f1_latched  out  32  f1_value captured at window end
- symbol  out  1  1 if f1_latched > f0_latched, else 0
- symbol_error  out  1  window invalid: both counts < MIN_COUNT, or tie
- result_valid  out  1  one-cycle pulse; the latched outputs are stable from this pulse until the next pulse
- busy  out  1  high in every state except IDLE
- window_count  out  16  completed windows; wraps 0xFFFF->0

Behaviour:
- Reset values:
  - analyzer_enable=0, analyzer_clear=0 (analyzer held cleared).
  - f0/f1_latched=0, symbol=0, symbol_error=0, result_valid=0, busy=0, window_count=0.
  - Timer=0, state=IDLE.
- States: IDLE, CLEAR, GUARD, MEASURE, SETTLE, DECIDE. All outputs are registered.
- IDLE:
  - analyzer_clear=0, analyzer_enable=0.
  - start=1 -> CLEAR.
- CLEAR:
  - Exactly 1 cycle, analyzer_clear=0.
  - -> GUARD if GUARD_TICKS>0, else -> MEASURE.
- GUARD:
  - analyzer_clear=1, analyzer_enable=0, for GUARD_TICKS cycles.
  - -> MEASURE.
- MEASURE:
  - analyzer_clear=1, analyzer_enable=1, for exactly WINDOW_TICKS cycles.
  - -> SETTLE.
- SETTLE:
  - analyzer_enable=0, analyzer_clear=1, for SETTLE_TICKS cycles.
  - On the SETTLE->DECIDE edge, capture f0_value/f1_value into f0/f1_latched and compute symbol/symbol_error.
- DECIDE:
  - 1 cycle; result_valid=1; window_count increments here.
  - continuous=1 -> CLEAR; else -> IDLE.
- Timing, with start sampled high in IDLE at cycle 0:
  - CLEAR at cycle 1.
  - GUARD at cycles 2..G+1.
  - MEASURE at cycles G+2..G+W+1.
  - SETTLE at cycles G+W+2..G+W+1+S.
  - result_valid at cycle G+W+S+2.
  - Continuous period = G+W+S+2 cycles.
- Decision rule (32-bit unsigned compare):
  - Error if f0<MIN_COUNT and f1<MIN_COUNT, or f0==f1.
  - On error, symbol=0.
  - Otherwise symbol=(f1>f0).
- Timer: single 32-bit down-counter, loaded on each state entry, with transition at terminal count. No zero-length states except the skipped GUARD.
- start while busy: ignored, not queued.
- continuous dropped mid-window: the current window completes; return to IDLE at DECIDE.
- reset mid-window: next cycle is IDLE with reset values; partial results are discarded; the analyzer is cleared.
- start and reset in the same cycle: reset wins.

Decomposition:
- Shared package (fsk_pkg):
  - State encoding enum.
  - SYMBOL_F0=0, SYMBOL_F1=1.
  - Default WINDOW/GUARD/SETTLE constants derived from CLOCK_FREQUENCY=50_000_000.
- One natural sub-module, window_timer:
  - Loadable 32-bit down-counter with a done flag.
  - Ports: clock, reset, load, load_value, done.

Test Plan:
- Reset then idle (W=100, G=10, S=2):
  - Hold start=0 for 50 cycles -> analyzer_clear=0, analyzer_enable=0, busy=0, result_valid never high.
- Single window:
  - Pulse start at cycle 0; drive f0=300, f1=2000 with MIN_COUNT=1000.
  - -> analyzer_clear low only at cycle 1.
  - -> analyzer_enable high cycles 12..111.
  - -> result_valid at cycle 114 with symbol=1, symbol_error=0, f1_latched=2000; window_count=1.
- Invalid / tie windows:
  - f0=f1=1500 -> symbol_error=1, symbol=0.
  - f0=200, f1=900 -> symbol_error=1, symbol=0.
- Continuous mode:
  - continuous=1 with start pulse -> result_valid every 114 cycles.
  - Drop continuous at cycle 200 -> the valid at cycle 228 is the last; IDLE at cycle 229; window_count=2.
- Reset and start interplay:
  - Assert reset at cycle 60 -> cycle 61 is IDLE with all outputs at reset values; no result_valid.
  - start asserted in cycles 5..20 -> no second window, no extra result_valid.
- window_count wrap:
  - With window_count preset to 0xFFFF (force, or run 65535 windows at W=1, G=0) -> the next DECIDE gives window_count=0x0000.

Source files
------------

// File: rtl/fsk_window_controller_pkg.sv
// Shared definitions for the FSK window controller: state encoding,
// symbol values, default timing derived from the system clock, and the
// per-window symbol decision rule.
package fsk_pkg;

   localparam int CLOCK_FREQUENCY      = 50_000_000;
   localparam int DEFAULT_WINDOW_TICKS = CLOCK_FREQUENCY / 1000;     // 1 ms
   localparam int DEFAULT_GUARD_TICKS  = CLOCK_FREQUENCY / 100_000;  // 10 us
   localparam int DEFAULT_SETTLE_TICKS = 2;
   localparam int DEFAULT_MIN_COUNT    = 1000;

   localparam logic SYMBOL_F0 = 1'b0;
   localparam logic SYMBOL_F1 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GUARD,
      ST_MEASURE,
      ST_SETTLE,
      ST_DECIDE
   } state_t;

   typedef struct packed {
      logic symbol;
      logic symbol_error;
   } decision_t;

   // A window is invalid when neither tone accumulated enough counts or
   // when the two counts tie; an invalid window always reports SYMBOL_F0.
   function automatic decision_t decide(input logic [31:0] f0,
                                        input logic [31:0] f1,
                                        input logic [31:0] min_count);
      decision_t d;
      d.symbol_error = ((f0 < min_count) && (f1 < min_count)) || (f0 == f1);
      if (d.symbol_error)
         d.symbol = SYMBOL_F0;
      else
         d.symbol = (f1 > f0) ? SYMBOL_F1 : SYMBOL_F0;
      return d;
   endfunction

endpackage

// File: rtl/fsk_window_controller_if.sv
// Signal bundle between the window controller and its surroundings:
// control inputs, analyzer drive/readback, and the per-window result.
interface fsk_window_controller_if;

   logic        start;
   logic        continuous;
   logic        analyzer_enable;
   logic        analyzer_clear;
   logic [31:0] f0_value;
   logic [31:0] f1_value;
   logic [31:0] f0_latched;
   logic [31:0] f1_latched;
   logic        symbol;
   logic        symbol_error;
   logic        result_valid;
   logic        busy;
   logic [15:0] window_count;

   // Controller side
   modport master (
      input  start, continuous, f0_value, f1_value,
      output analyzer_enable, analyzer_clear, f0_latched, f1_latched,
             symbol, symbol_error, result_valid, busy, window_count
   );

   // Environment side (analyzer + consumer)
   modport slave (
      output start, continuous, f0_value, f1_value,
      input  analyzer_enable, analyzer_clear, f0_latched, f1_latched,
             symbol, symbol_error, result_valid, busy, window_count
   );

endinterface

// File: rtl/fsk_window_controller_window_timer.sv
// Loadable 32-bit down-counter. Loading N makes done assert N cycles
// later, so a state lasting D cycles is loaded with D-1 on entry.
module window_timer (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_value,
   output logic        done
);

   logic [31:0] count_reg;

   // Count down to zero and hold there until the next load
   always_ff @(posedge clock) begin
      if (reset)
         count_reg <= 32'd0;
      else if (load)
         count_reg <= load_value;
      else if (count_reg != 32'd0)
         count_reg <= count_reg - 32'd1;
   end

   assign done = (count_reg == 32'd0);

endmodule

// File: rtl/fsk_window_controller.sv
// Sequences a frequency analyzer through clear / guard / measure / settle
// and issues one symbol decision per window. All outputs are registered
// from the next-state value so they line up with the state they describe.
module fsk_window_controller
   import fsk_pkg::*;
#(
   parameter int WINDOW_TICKS = DEFAULT_WINDOW_TICKS,
   parameter int GUARD_TICKS  = DEFAULT_GUARD_TICKS,
   parameter int MIN_COUNT    = DEFAULT_MIN_COUNT,
   parameter int SETTLE_TICKS = DEFAULT_SETTLE_TICKS
) (
   input  logic                     clock,
   input  logic                     reset,
   fsk_window_controller_if.master  bus
);

   localparam logic [31:0] WINDOW_LOAD = 32'(WINDOW_TICKS - 1);
   localparam logic [31:0] GUARD_LOAD  = 32'(GUARD_TICKS - 1);
   localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_TICKS - 1);
   localparam logic [31:0] MIN_VALUE   = 32'(MIN_COUNT);

   state_t      state_reg;
   state_t      state_next;
   logic        timer_load;
   logic [31:0] timer_load_value;
   logic        timer_done;
   decision_t   decision_next;

   logic        analyzer_enable_reg;
   logic        analyzer_clear_reg;
   logic [31:0] f0_latched_reg;
   logic [31:0] f1_latched_reg;
   decision_t   decision_reg;
   logic        result_valid_reg;
   logic        busy_reg;
   logic [15:0] window_count_reg;

   window_timer u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_load_value),
      .done       (timer_done)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; timed states leave when the timer reaches zero
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (bus.start) state_next = ST_CLEAR;
         ST_CLEAR:   state_next = (GUARD_TICKS > 0) ? ST_GUARD : ST_MEASURE;
         ST_GUARD:   if (timer_done) state_next = ST_MEASURE;
         ST_MEASURE: if (timer_done) state_next = ST_SETTLE;
         ST_SETTLE:  if (timer_done) state_next = ST_DECIDE;
         ST_DECIDE:  state_next = bus.continuous ? ST_CLEAR : ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Reload the timer on every state entry with that state's length minus one
   always_comb begin
      timer_load       = (state_next != state_reg);
      timer_load_value = 32'd0;
      case (state_next)
         ST_GUARD:   timer_load_value = GUARD_LOAD;
         ST_MEASURE: timer_load_value = WINDOW_LOAD;
         ST_SETTLE:  timer_load_value = SETTLE_LOAD;
         default:    timer_load_value = 32'd0;
      endcase
   end

   assign decision_next = decide(bus.f0_value, bus.f1_value, MIN_VALUE);

   // Registered outputs; results are captured as SETTLE hands over to DECIDE
   always_ff @(posedge clock) begin
      if (reset) begin
         analyzer_enable_reg <= 1'b0;
         analyzer_clear_reg  <= 1'b0;
         f0_latched_reg      <= 32'd0;
         f1_latched_reg      <= 32'd0;
         decision_reg        <= '0;
         result_valid_reg    <= 1'b0;
         busy_reg            <= 1'b0;
         window_count_reg    <= 16'd0;
      end else begin
         analyzer_enable_reg <= (state_next == ST_MEASURE);
         analyzer_clear_reg  <= (state_next != ST_IDLE) && (state_next != ST_CLEAR);
         result_valid_reg    <= (state_next == ST_DECIDE);
         busy_reg            <= (state_next != ST_IDLE);
         if ((state_reg == ST_SETTLE) && (state_next == ST_DECIDE)) begin
            f0_latched_reg   <= bus.f0_value;
            f1_latched_reg   <= bus.f1_value;
            decision_reg     <= decision_next;
            window_count_reg <= window_count_reg + 16'd1;
         end
      end
   end

   assign bus.analyzer_enable = analyzer_enable_reg;
   assign bus.analyzer_clear  = analyzer_clear_reg;
   assign bus.f0_latched      = f0_latched_reg;
   assign bus.f1_latched      = f1_latched_reg;
   assign bus.symbol          = decision_reg.symbol;
   assign bus.symbol_error    = decision_reg.symbol_error;
   assign bus.result_valid    = result_valid_reg;
   assign bus.busy            = busy_reg;
   assign bus.window_count    = window_count_reg;

endmodule

// File: tb/tb_fsk_window_controller.sv
// Bench for fsk_window_controller: directed decision table, randomized
// windows against a reference decision/schedule model, and hand-written
// sequences for continuous mode, reset, start-while-busy and count wrap.
module tb_fsk_window_controller;

   localparam int W    = 100;
   localparam int G    = 10;
   localparam int S    = 2;
   localparam int MINC = 1000;
   localparam int P    = G + W + S + 2;   // cycles from start to result_valid
   localparam logic [31:0] MIN32 = 32'(MINC);

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fsk_window_controller_if bus ();

   fsk_window_controller #(
      .WINDOW_TICKS (W),
      .GUARD_TICKS  (G),
      .MIN_COUNT    (MINC),
      .SETTLE_TICKS (S)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] f0;
      logic [31:0] f1;
      logic        exp_symbol;
      logic        exp_error;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [15:0] exp_count = 16'd0;

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference decision: plain arithmetic on the rule
   function automatic logic ref_error(input logic [31:0] f0, input logic [31:0] f1);
      return ((f0 < MIN32) && (f1 < MIN32)) || (f0 == f1);
   endfunction

   function automatic logic ref_symbol(input logic [31:0] f0, input logic [31:0] f1);
      if (ref_error(f0, f1)) return 1'b0;
      return (f1 > f0);
   endfunction

   // Reference schedule: nwin back-to-back windows starting after cycle 0
   task automatic check_sched(input int t, input int nwin);
      int   r;
      logic e_clr, e_en, e_val, e_busy;
      if (t >= 1 && t <= nwin * P) begin
         r      = ((t - 1) % P) + 1;
         e_clr  = (r != 1);
         e_en   = (r >= G + 2) && (r <= G + W + 1);
         e_val  = (r == P);
         e_busy = 1'b1;
      end else begin
         e_clr = 1'b0; e_en = 1'b0; e_val = 1'b0; e_busy = 1'b0;
      end
      check1("analyzer_clear", bus.analyzer_clear, e_clr);
      check1("analyzer_enable", bus.analyzer_enable, e_en);
      check1("result_valid", bus.result_valid, e_val);
      check1("busy", bus.busy, e_busy);
   endtask

   // One single-shot window; inputs carry junk except in the capture cycle
   task automatic run_window(input logic [31:0] f0, input logic [31:0] f1,
                             input logic es, input logic ee);
      bus.start    = 1'b1;
      bus.f0_value = $urandom;
      bus.f1_value = $urandom;
      cyc = 0;
      for (int t = 1; t <= P + 1; t++) begin
         tick();
         bus.start = 1'b0;
         if (t == P - 1) begin
            bus.f0_value = f0;
            bus.f1_value = f1;
         end else begin
            bus.f0_value = $urandom;
            bus.f1_value = $urandom;
         end
         if (t == P) exp_count++;
         check_sched(t, 1);
         if (t >= P) begin
            check32("f0_latched", bus.f0_latched, f0);
            check32("f1_latched", bus.f1_latched, f1);
            check1("symbol", bus.symbol, es);
            check1("symbol_error", bus.symbol_error, ee);
            check32("window_count", {16'd0, bus.window_count}, {16'd0, exp_count});
         end
      end
      $display("window f0=%0d f1=%0d symbol=%0d error=%0d count=%0d",
               f0, f1, bus.symbol, bus.symbol_error, bus.window_count);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[11];
      logic [31:0] rf0, rf1;

      vecs[0]  = '{32'd300,        32'd2000,       1'b1, 1'b0};
      vecs[1]  = '{32'd2000,       32'd300,        1'b0, 1'b0};
      vecs[2]  = '{32'd1500,       32'd1500,       1'b0, 1'b1};
      vecs[3]  = '{32'd200,        32'd900,        1'b0, 1'b1};
      vecs[4]  = '{32'd999,        32'd1000,       1'b1, 1'b0};
      vecs[5]  = '{32'd1000,       32'd999,        1'b0, 1'b0};
      vecs[6]  = '{32'd999,        32'd999,        1'b0, 1'b1};
      vecs[7]  = '{32'd0,          32'd0,          1'b0, 1'b1};
      vecs[8]  = '{32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b0};
      vecs[9]  = '{32'h8000_0000,  32'd5,          1'b0, 1'b0};
      vecs[10] = '{32'd0,          32'd1000,       1'b1, 1'b0};

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.continuous = 1'b0;
      bus.f0_value   = 32'd0;
      bus.f1_value   = 32'd0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state, then 50 idle cycles
      cyc = 0;
      check32("reset_f0_latched", bus.f0_latched, 32'd0);
      check32("reset_f1_latched", bus.f1_latched, 32'd0);
      check1("reset_symbol", bus.symbol, 1'b0);
      check1("reset_symbol_error", bus.symbol_error, 1'b0);
      check32("reset_window_count", {16'd0, bus.window_count}, 32'd0);
      for (int t = 0; t < 50; t++) begin
         tick();
         check_sched(0, 0);
      end
      $display("idle 50 cycles busy=%0d", bus.busy);

      // Directed decision table
      for (int i = 0; i < 11; i++)
         run_window(vecs[i].f0, vecs[i].f1, vecs[i].exp_symbol, vecs[i].exp_error);

      // Randomized windows against the reference decision
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 3))
            0: begin rf0 = $urandom; rf1 = $urandom; end
            1: begin rf0 = $urandom_range(0, 2000); rf1 = $urandom_range(0, 2000); end
            2: begin rf0 = $urandom_range(0, 3000); rf1 = rf0; end
            default: begin rf0 = $urandom_range(990, 1010); rf1 = $urandom_range(990, 1010); end
         endcase
         run_window(rf0, rf1, ref_symbol(rf0, rf1), ref_error(rf0, rf1));
      end

      // Continuous mode, dropped at cycle 200: last valid at 2P, idle after
      bus.f0_value   = 32'd300;
      bus.f1_value   = 32'd2000;
      bus.continuous = 1'b1;
      bus.start      = 1'b1;
      cyc = 0;
      for (int t = 1; t <= 2 * P + 12; t++) begin
         tick();
         bus.start = 1'b0;
         if (t == 200) bus.continuous = 1'b0;
         if (t == P || t == 2 * P) begin
            exp_count++;
            check1("cont_symbol", bus.symbol, 1'b1);
            check32("cont_window_count", {16'd0, bus.window_count}, {16'd0, exp_count});
         end
         check_sched(t, 2);
      end
      $display("continuous run done count=%0d", bus.window_count);

      // start held during a window is ignored
      bus.start = 1'b1;
      cyc = 0;
      for (int t = 1; t <= P + 130; t++) begin
         tick();
         bus.start = (t >= 5 && t <= 20);
         if (t == P) exp_count++;
         check_sched(t, 1);
      end
      check32("busy_start_count", {16'd0, bus.window_count}, {16'd0, exp_count});
      $display("start-while-busy done count=%0d", bus.window_count);

      // Reset in the middle of a window
      bus.f0_value = 32'd2000;
      bus.f1_value = 32'd300;
      bus.start    = 1'b1;
      cyc = 0;
      for (int t = 1; t <= 60; t++) begin
         tick();
         bus.start = 1'b0;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_count = 16'd0;
      check1("midreset_enable", bus.analyzer_enable, 1'b0);
      check1("midreset_clear", bus.analyzer_clear, 1'b0);
      check1("midreset_busy", bus.busy, 1'b0);
      check1("midreset_valid", bus.result_valid, 1'b0);
      check32("midreset_f0_latched", bus.f0_latched, 32'd0);
      check32("midreset_f1_latched", bus.f1_latched, 32'd0);
      check1("midreset_symbol", bus.symbol, 1'b0);
      check1("midreset_error", bus.symbol_error, 1'b0);
      check32("midreset_count", {16'd0, bus.window_count}, 32'd0);
      for (int t = 0; t < 150; t++) begin
         tick();
         check_sched(0, 0);
      end
      $display("mid-window reset done busy=%0d", bus.busy);

      // start and reset together: reset wins
      bus.start = 1'b1;
      reset     = 1'b1;
      tick();
      bus.start = 1'b0;
      reset     = 1'b0;
      check1("start_reset_busy", bus.busy, 1'b0);
      tick();
      check_sched(0, 0);
      $display("start+reset same cycle busy=%0d", bus.busy);

      // window_count wraps 0xFFFF -> 0
      force dut.window_count_reg = 16'hFFFF;
      tick();
      release dut.window_count_reg;
      tick();
      exp_count = 16'hFFFF;
      run_window(32'd300, 32'd2000, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
